nios_usb_rst_seq: RTL and testbench

//  Avalon-MM slave that sequences the USB controller's active-low hardware reset.

---
 rtl/nios_usb_rst_seq.sv | 141 ++++++++++++++
 tb/tb_nios_usb_rst_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nios_usb_rst_seq.sv
// Avalon-MM slave that sequences the USB controller's active-low hardware reset:
// a timed assert pulse, a programmable settle wait, then a done flag and optional IRQ.
module nios_usb_rst_seq #(
   parameter int CNT_W     = 20,
   parameter int DEF_PULSE = 500000,
   parameter int DEF_WAIT  = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        usb_rst_n,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ASSERT = 2'd1,
      S_WAIT   = 2'd2
   } state_e;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_PULSE  = 2'd2;
   localparam logic [1:0] A_WAIT   = 2'd3;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  pulse_len_q, pulse_len_d;
   logic [CNT_W-1:0]  wait_len_q, wait_len_d;
   logic              force_q, force_d;
   logic              irq_en_q, irq_en_d;
   logic              done_q, done_d;
   logic              usb_rst_n_q, usb_rst_n_d;

   logic              wr_en;
   logic              start;
   logic              unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign start        = wr_en && (address == A_CTRL) && writedata[0];
   assign unused_wdata = ^writedata[31:CNT_W];

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pulse_len_d = pulse_len_q;
      wait_len_d  = wait_len_q;
      force_d     = force_q;
      irq_en_d    = irq_en_q;
      done_d      = done_q;

      if (wr_en) begin
         case (address)
            A_CTRL: begin
               force_d  = writedata[1];
               irq_en_d = writedata[2];
            end
            A_STATUS: if (writedata[1]) done_d = 1'b0;
            A_PULSE:  pulse_len_d = writedata[CNT_W-1:0];
            A_WAIT:   wait_len_d  = writedata[CNT_W-1:0];
            default: ;
         endcase
      end

      // FSM updates come after the W1C clear so a same-cycle done-set wins.
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ASSERT;
               cnt_d   = (pulse_len_q == '0) ? '0 : pulse_len_q - 1'b1;
               done_d  = 1'b0;
            end
         end
         S_ASSERT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (wait_len_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_WAIT;
               cnt_d   = wait_len_q - 1'b1;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      usb_rst_n_d = ~(force_d | (state_d == S_ASSERT));
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pulse_len_q <= CNT_W'(DEF_PULSE);
         wait_len_q  <= CNT_W'(DEF_WAIT);
         force_q     <= 1'b1;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         usb_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pulse_len_q <= pulse_len_d;
         wait_len_q  <= wait_len_d;
         force_q     <= force_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         usb_rst_n_q <= usb_rst_n_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         A_CTRL:   readdata = {29'b0, irq_en_q, force_q, 1'b0};
         A_STATUS: readdata = {30'b0, done_q, state_q != S_IDLE};
         A_PULSE:  readdata = 32'(pulse_len_q);
         A_WAIT:   readdata = 32'(wait_len_q);
         default:  readdata = '0;
      endcase
   end

   assign usb_rst_n = usb_rst_n_q;
   assign irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_nios_usb_rst_seq.sv
// Directed bench for nios_usb_rst_seq: register table plus hand-timed reset sequences.
module tb_nios_usb_rst_seq;

   localparam int CNT_W     = 20;
   localparam int DEF_PULSE = 500000;
   localparam int DEF_WAIT  = 50000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        usb_rst_n;
   logic        irq;

   int n_vec = 0;
   int n_bad = 0;

   nios_usb_rst_seq #(
      .CNT_W(CNT_W), .DEF_PULSE(DEF_PULSE), .DEF_WAIT(DEF_WAIT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .usb_rst_n(usb_rst_n), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [1:0]  waddr;
      logic [31:0] wdata;
      logic [1:0]  raddr;
      logic [31:0] exp_rd;
      logic        exp_rst_n;
      logic        exp_irq;
      string       name;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One-cycle bus write; returns 1 time unit after the edge that accepted it.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Called right after the START write; k counts edges since that write.
   task automatic check_seq(input string tag, input int p, input int w, input bit hold,
                            input bit irq_en, input int k0);
      address = 2'd1;
      #1;
      for (int k = k0; k <= p + w + 1; k++) begin
         check($sformatf("%s_rst_k%0d", tag, k), 32'(usb_rst_n), 32'((!hold) && (k >= p)));
         check($sformatf("%s_status_k%0d", tag, k), readdata, (k < p + w) ? 32'h1 : 32'h2);
         check($sformatf("%s_irq_k%0d", tag, k), 32'(irq), 32'(irq_en && (k >= p + w)));
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h2,       1'b0, 1'b0, "reset_ctrl"};
      vecs[1] = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0,       1'b0, 1'b0, "reset_status"};
      vecs[2] = '{1'b0, 2'd0, 32'h0,         2'd2, DEF_PULSE,   1'b0, 1'b0, "reset_pulse"};
      vecs[3] = '{1'b0, 2'd0, 32'h0,         2'd3, DEF_WAIT,    1'b0, 1'b0, "reset_wait"};
      vecs[4] = '{1'b1, 2'd2, 32'hFFF0_0008, 2'd2, 32'h8,       1'b0, 1'b0, "pulse_trunc"};
      vecs[5] = '{1'b1, 2'd3, 32'h4,         2'd3, 32'h4,       1'b0, 1'b0, "wait_wr"};
      vecs[6] = '{1'b1, 2'd0, 32'h0,         2'd0, 32'h0,       1'b1, 1'b0, "force_clr"};
      vecs[7] = '{1'b1, 2'd0, 32'h6,         2'd0, 32'h6,       1'b0, 1'b0, "force_irqen"};
      vecs[8] = '{1'b1, 2'd0, 32'h0,         2'd0, 32'h0,       1'b1, 1'b0, "ctrl_clr"};
      vecs[9] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0,       1'b1, 1'b0, "status_w1c_idle"};

      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
         else @(negedge clk);
         address = vecs[i].raddr;
         #1;
         check({vecs[i].name, "_rd"}, readdata, vecs[i].exp_rd);
         check({vecs[i].name, "_rst"}, 32'(usb_rst_n), 32'(vecs[i].exp_rst_n));
         check({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
      end

      // 8-cycle pulse, 4-cycle settle
      wr(2'd0, 32'h1);
      check_seq("seq8_4", 8, 4, 1'b0, 1'b0, 0);

      // IRQ follows done; W1C needs bit1
      wr(2'd0, 32'h4);
      wr(2'd0, 32'h5);
      check_seq("irq", 8, 4, 1'b0, 1'b1, 0);
      wr(2'd1, 32'h1);
      address = 2'd1;
      #1;
      check("w1c_bit0_status", readdata, 32'h2);
      check("w1c_bit0_irq", 32'(irq), 32'h1);
      wr(2'd1, 32'h2);
      address = 2'd1;
      #1;
      check("w1c_status", readdata, 32'h0);
      check("w1c_irq", 32'(irq), 32'h0);

      // zero lengths: 1-cycle pulse, done right after
      wr(2'd2, 32'h0);
      wr(2'd3, 32'h0);
      wr(2'd0, 32'h5);
      check_seq("zero", 1, 0, 1'b0, 1'b1, 0);

      // done-set and done-clear on the same edge: set wins
      wr(2'd0, 32'h5);
      wr(2'd1, 32'h2);
      address = 2'd1;
      #1;
      check("set_wins_status", readdata, 32'h2);
      check("set_wins_irq", 32'(irq), 32'h1);

      // START while busy ignored; PULSE_LEN write mid-run affects next run only
      wr(2'd2, 32'h8);
      wr(2'd3, 32'h4);
      wr(2'd0, 32'h5);
      wr(2'd2, 32'h3);
      wr(2'd0, 32'h5);
      check_seq("restart", 8, 4, 1'b0, 1'b1, 2);
      address = 2'd2;
      #1;
      check("pulse_readback", readdata, 32'h3);
      wr(2'd0, 32'h5);
      check_seq("next_run", 3, 4, 1'b0, 1'b1, 0);

      // START+FORCE: sequence completes, pin held until FORCE cleared
      wr(2'd0, 32'h7);
      check_seq("force", 3, 4, 1'b1, 1'b1, 0);
      wr(2'd0, 32'h4);
      check("force_release_rst", 32'(usb_rst_n), 32'h1);

      // async reset while in WAIT
      wr(2'd0, 32'h5);
      address = 2'd1;
      repeat (4) @(posedge clk);
      #2;
      check("pre_reset_busy", readdata, 32'h1);
      reset_n = 1'b0;
      #1;
      check("areset_rst", 32'(usb_rst_n), 32'h0);
      check("areset_status", readdata, 32'h0);
      check("areset_irq", 32'(irq), 32'h0);
      address = 2'd0;
      #1;
      check("areset_ctrl", readdata, 32'h2);
      address = 2'd2;
      #1;
      check("areset_pulse", readdata, DEF_PULSE);
      address = 2'd3;
      #1;
      check("areset_wait", readdata, DEF_WAIT);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
